// File: rtl/dmem_tcm.sv
// Single-ported tightly-coupled data memory with a fixed-latency valid/ready responder.
// Optional macro DMEM_TCM_BOUNDS_CHECK_EN adds a BASE_ADDR window check with error responses.
module dmem_tcm #(
  parameter int unsigned ADDR_W    = 12,
  parameter int unsigned LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h0000_0000_8000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic        dm_req_ready,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic        dm_resp_err
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [63:0]       pendData_q, pendData_d;
  logic              pendErr_q, pendErr_d;
  logic [63:0]       rdata_q, rdata_d;
  logic              err_q, err_d;

  logic [63:0]       mem [DEPTH];
  logic              accept;
  logic              inWin;
  logic [ADDR_W-1:0] idx;
  logic [63:0]       accData;
  logic              accErr;
  logic [63:0]       unusedBase;

  assign unusedBase = BASE_ADDR;

`ifdef DMEM_TCM_BOUNDS_CHECK_EN
  logic [63:0] offset;
  logic [2:0]  unusedOffset;

  assign offset       = dm_req_addr - BASE_ADDR;
  assign inWin        = (offset[63:ADDR_W+3] == '0);
  assign idx          = offset[ADDR_W+2:3];
  assign unusedOffset = offset[2:0];
`else
  logic [63-ADDR_W:0] unusedAddr;

  // Without the window check, addresses simply alias modulo the depth.
  assign inWin      = 1'b1;
  assign idx        = dm_req_addr[ADDR_W+2:3];
  assign unusedAddr = {dm_req_addr[63:ADDR_W+3], dm_req_addr[2:0]};
`endif

  assign accept  = dm_req_valid && dm_req_ready;
  assign accErr  = !inWin;
  assign accData = (dm_req_wen || !inWin) ? 64'h0 : mem[idx];

  always_ff @(posedge clk) begin
    if (accept && dm_req_wen && inWin) begin
      for (int i = 0; i < 8; i++) begin
        if (dm_req_wmask[i]) begin
          mem[idx][8*i +: 8] <= dm_req_wdata[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      pendData_q <= 64'h0;
      pendErr_q  <= 1'b0;
      rdata_q    <= 64'h0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pendData_q <= pendData_d;
      pendErr_q  <= pendErr_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
    end
  end

  // RESP accepts like IDLE so that back-to-back requests keep the pipe full.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE, RESP: begin
        if (accept) begin
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = 4'(LATENCY - 2);
          end
        end else if (state_q == RESP) begin
          state_d = IDLE;
        end
      end
      WAIT: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Visible response data only changes on entry to RESP, so it holds between responses.
  always_comb begin
    pendData_d = pendData_q;
    pendErr_d  = pendErr_q;
    rdata_d    = rdata_q;
    err_d      = err_q;
    if (accept) begin
      pendData_d = accData;
      pendErr_d  = accErr;
    end
    if (accept && (LATENCY == 1)) begin
      rdata_d = accData;
      err_d   = accErr;
    end else if ((state_q == WAIT) && (cnt_q == 4'd0)) begin
      rdata_d = pendData_q;
      err_d   = pendErr_q;
    end
  end

  assign dm_req_ready  = (state_q != WAIT);
  assign dm_resp_valid = (state_q == RESP);
  assign dm_resp_rdata = rdata_q;
  assign dm_resp_err   = err_q;

endmodule

// File: tb/tb_dmem_tcm.sv
// Directed self-checking bench for dmem_tcm: one instance at LATENCY=1, one at LATENCY=3.
// Window-check steps compile only when DMEM_TCM_BOUNDS_CHECK_EN is defined; otherwise aliasing is checked.
module tb_dmem_tcm;

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic [63:0] aAddr, aWdata, aRdata;
  logic [7:0]  aWmask;
  logic        aWen, aValid, aReady, aRespValid, aRespErr;

  logic [63:0] bAddr, bWdata, bRdata;
  logic [7:0]  bWmask;
  logic        bWen, bValid, bReady, bRespValid, bRespErr;

  int testsRun  = 0;
  int failCount = 0;

  always #5 clk = ~clk;

  dmem_tcm #(.ADDR_W(12), .LATENCY(1)) u1 (
    .clk(clk), .rst(rst),
    .dm_req_addr(aAddr), .dm_req_wdata(aWdata), .dm_req_wmask(aWmask),
    .dm_req_wen(aWen), .dm_req_valid(aValid), .dm_req_ready(aReady),
    .dm_resp_rdata(aRdata), .dm_resp_valid(aRespValid), .dm_resp_err(aRespErr)
  );

  dmem_tcm #(.ADDR_W(12), .LATENCY(3)) u3 (
    .clk(clk), .rst(rst),
    .dm_req_addr(bAddr), .dm_req_wdata(bWdata), .dm_req_wmask(bWmask),
    .dm_req_wen(bWen), .dm_req_valid(bValid), .dm_req_ready(bReady),
    .dm_resp_rdata(bRdata), .dm_resp_valid(bRespValid), .dm_resp_err(bRespErr)
  );

  // Counts one comparison and reports it when observed differs from expected.
  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    testsRun++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Issues one request on the LATENCY=1 instance and checks its response one cycle later.
  task automatic applyStimulus(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wmask, input logic [63:0] expRdata,
                               input logic expErr, input string tag);
    @(negedge clk);
    aValid = 1'b1;
    aWen   = wen;
    aAddr  = addr;
    aWdata = wdata;
    aWmask = wmask;
    checkOutput({tag, ".ready"}, 64'(aReady), 64'd1);
    @(posedge clk);
    #1;
    checkOutput({tag, ".valid"}, 64'(aRespValid), 64'd1);
    checkOutput({tag, ".rdata"}, aRdata, expRdata);
    checkOutput({tag, ".err"}, 64'(aRespErr), 64'(expErr));
  endtask

  // Drives the whole directed sequence, from reset through both instances.
  initial begin
    int respSeen;
    int lastResp;
    int k;
    logic expValid;
    logic expReady;

    aAddr = '0; aWdata = '0; aWmask = '0; aWen = 1'b0; aValid = 1'b0;
    bAddr = '0; bWdata = '0; bWmask = '0; bWen = 1'b0; bValid = 1'b0;
    respSeen = 0;
    lastResp = -1;

    #1;
    checkOutput("rst.a.ready", 64'(aReady), 64'd1);
    checkOutput("rst.a.valid", 64'(aRespValid), 64'd0);
    checkOutput("rst.a.rdata", aRdata, 64'h0);
    checkOutput("rst.a.err", 64'(aRespErr), 64'd0);
    checkOutput("rst.b.ready", 64'(bReady), 64'd1);
    checkOutput("rst.b.valid", 64'(bRespValid), 64'd0);
    checkOutput("rst.b.rdata", bRdata, 64'h0);
    checkOutput("rst.b.err", 64'(bRespErr), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Full store followed immediately by a load of the same word.
    applyStimulus(1'b1, 64'h8000_0010, 64'h1122334455667788, 8'hFF, 64'h0, 1'b0, "l1.store");
    applyStimulus(1'b0, 64'h8000_0010, 64'h0, 8'h00, 64'h1122334455667788, 1'b0, "l1.load");
    @(negedge clk);
    aValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("l1.idle.valid", 64'(aRespValid), 64'd0);
    checkOutput("l1.idle.rdata_hold", aRdata, 64'h1122334455667788);

    // Partial byte-lane merge, then an all-zero mask store that must change nothing.
    applyStimulus(1'b1, 64'h8000_0020, 64'h0, 8'hFF, 64'h0, 1'b0, "mask.clear");
    applyStimulus(1'b1, 64'h8000_0020, 64'hAAAAAAAAAAAAAAAA, 8'h0C, 64'h0, 1'b0, "mask.0c");
    applyStimulus(1'b1, 64'h8000_0020, 64'hFFFFFFFFFFFFFFFF, 8'h00, 64'h0, 1'b0, "mask.00");
    applyStimulus(1'b0, 64'h8000_0020, 64'h0, 8'hFF, 64'h00000000AAAA0000, 1'b0, "mask.load");

`ifdef DMEM_TCM_BOUNDS_CHECK_EN
    applyStimulus(1'b1, 64'h8000_0000, 64'h0123456789ABCDEF, 8'hFF, 64'h0, 1'b0, "win.seed");
    applyStimulus(1'b0, 64'h7FFF_FFF8, 64'h0, 8'h00, 64'h0, 1'b1, "win.load_below");
    applyStimulus(1'b1, 64'h8000_8000, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'h0, 1'b1, "win.store_above");
    applyStimulus(1'b0, 64'h8000_0000, 64'h0, 8'h00, 64'h0123456789ABCDEF, 1'b0, "win.load_base");
`else
    applyStimulus(1'b1, 64'h0000_8000, 64'h0F1E2D3C4B5A6978, 8'hFF, 64'h0, 1'b0, "alias.store");
    applyStimulus(1'b0, 64'h0000_0000, 64'h0, 8'h00, 64'h0F1E2D3C4B5A6978, 1'b0, "alias.load");
`endif
    @(negedge clk);
    aValid = 1'b0;

    // LATENCY=3: four stores then four loads with valid held high, one accept every 3 cycles.
    for (int c = 0; c < 27; c++) begin
      @(negedge clk);
      if (c < 24) begin
        if (c % 3 == 0) begin
          k      = c / 3;
          bValid = 1'b1;
          bWen   = (k < 4);
          bAddr  = 64'h8000_0100 + 64'(8 * (k % 4));
          bWdata = 64'hC0DE_0000_0000_0000 | 64'(k % 4);
          bWmask = 8'hFF;
        end
      end else begin
        bValid = 1'b0;
      end
      expReady = (c % 3 == 0) || (c >= 24);
      checkOutput($sformatf("l3.ready.c%0d", c), 64'(bReady), 64'(expReady));
      @(posedge clk);
      #1;
      expValid = (c >= 2) && ((c - 2) % 3 == 0) && ((c - 2) / 3 < 8);
      checkOutput($sformatf("l3.valid.c%0d", c), 64'(bRespValid), 64'(expValid));
      if (bRespValid) begin
        respSeen++;
        lastResp = c;
      end
      if (expValid) begin
        k = (c - 2) / 3;
        checkOutput($sformatf("l3.rdata.c%0d", c), bRdata,
                    (k < 4) ? 64'h0 : (64'hC0DE_0000_0000_0000 | 64'(k - 4)));
        checkOutput($sformatf("l3.err.c%0d", c), 64'(bRespErr), 64'd0);
      end
    end
    checkOutput("l3.resp_count", 64'(respSeen), 64'd8);
    checkOutput("l3.last_resp_cycle", 64'(lastResp), 64'd23);

    // Reset while a store waits: store stays committed, its response is dropped.
    @(negedge clk);
    bValid = 1'b1;
    bWen   = 1'b1;
    bAddr  = 64'h8000_0200;
    bWdata = 64'h5A5A5A5A5A5A5A5A;
    bWmask = 8'hFF;
    @(posedge clk);
    @(negedge clk);
    bValid = 1'b0;
    checkOutput("rstmid.wait_ready", 64'(bReady), 64'd0);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rstmid.ready", 64'(bReady), 64'd1);
    checkOutput("rstmid.valid", 64'(bRespValid), 64'd0);
    checkOutput("rstmid.rdata", bRdata, 64'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("rstmid.no_resp%0d", i), 64'(bRespValid), 64'd0);
    end
    @(negedge clk);
    bValid = 1'b1;
    bWen   = 1'b0;
    bAddr  = 64'h8000_0200;
    @(posedge clk);
    @(negedge clk);
    bValid = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("rstmid.load.v1", 64'(bRespValid), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rstmid.load.v2", 64'(bRespValid), 64'd1);
    checkOutput("rstmid.load.rdata", bRdata, 64'h5A5A5A5A5A5A5A5A);
    checkOutput("rstmid.load.err", 64'(bRespErr), 64'd0);
    @(posedge clk);
    #1;
    checkOutput("rstmid.load.v3", 64'(bRespValid), 64'd0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end

endmodule
